// File: rtl/store_pkg.sv
// store_pkg: size encodings and the store-buffer entry record shared by the store path.
package store_pkg;
  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;
  localparam int SB_ADDR_MAX = 64;
  localparam int SB_DATA_MAX = 64;
  localparam int SB_BE_MAX   = SB_DATA_MAX / 8;
  // Fields are sized for the widest configuration; narrower builds use the low bits.
  typedef struct packed {
    logic [SB_ADDR_MAX-1:0] addr;
    logic [SB_DATA_MAX-1:0] data;
    logic [SB_BE_MAX-1:0]   be;
  } sb_entry_t;
endpackage

// File: rtl/store_lane_align.sv
// store_lane_align: places right-justified store data onto byte lanes and flags misaligned or illegal sizes.
module store_lane_align
  import store_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB    = DATA_W / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic [1:0]        size,
  input  logic [OFF_W-1:0]  off,
  input  logic [DATA_W-1:0] data,
  output logic              fault,
  output logic [NB-1:0]     be,
  output logic [DATA_W-1:0] wdata
);
  logic illegal, mis;
  assign illegal = (size == SZ_DWORD) && (DATA_W == 32);
  assign mis = size == SZ_HALF  ? off[0] :
               size == SZ_WORD  ? |off[1:0] :
               size == SZ_DWORD ? |off : 1'b0;
  assign fault = illegal || mis;
  assign wdata = size == SZ_BYTE ? {NB{data[7:0]}} :
                 size == SZ_HALF ? {(NB/2){data[15:0]}} :
                 size == SZ_WORD ? {(DATA_W/32){data[31:0]}} : data;
  assign be = (size == SZ_BYTE ? NB'(1) :
               size == SZ_HALF ? NB'(3) :
               size == SZ_WORD ? NB'(15) : {NB{1'b1}}) << off;
endmodule

// File: rtl/store_buffer_unit.sv
// store_buffer_unit: in-order store buffer draining to data memory, with youngest-match load forwarding.
module store_buffer_unit
  import store_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4,
  localparam int NB    = DATA_W / 8,
  localparam int OFF_W = $clog2(NB),
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [1:0]        st_size,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_fault,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [NB-1:0]     mem_be,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [NB-1:0]     fwd_be,
  output logic [CNT_W-1:0]  count
);
  sb_entry_t entries [DEPTH];
  sb_entry_t new_e, head;
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] wr_ptr, rd_ptr, idx;
  logic [SB_ADDR_MAX-1:0] ld_w;
  logic al_fault, enq, deq, unused_ld;
  logic [NB-1:0] al_be;
  logic [DATA_W-1:0] al_wdata;
  store_lane_align #(.DATA_W(DATA_W)) u_align (
    .size  (st_size),
    .off   (st_addr[OFF_W-1:0]),
    .data  (st_data),
    .fault (al_fault),
    .be    (al_be),
    .wdata (al_wdata)
  );
  assign unused_ld = ^ld_addr[OFF_W-1:0];
  assign mem_valid = count != '0;
  assign st_ready  = (count < CNT_W'(DEPTH)) || (mem_valid && mem_ready);
  assign deq = mem_valid && mem_ready;
  assign enq = st_valid && st_ready && !al_fault;
  assign head = entries[rd_ptr];
  assign mem_addr  = mem_valid ? head.addr[ADDR_W-1:0] : '0;
  assign mem_wdata = mem_valid ? head.data[DATA_W-1:0] : '0;
  assign mem_be    = mem_valid ? head.be[NB-1:0] : '0;
  always_comb begin
    new_e = '0;
    new_e.addr[ADDR_W-1:OFF_W] = st_addr[ADDR_W-1:OFF_W];
    new_e.data[DATA_W-1:0] = al_wdata;
    new_e.be[NB-1:0] = al_be;
    ld_w = '0;
    ld_w[ADDR_W-1:OFF_W] = ld_addr[ADDR_W-1:OFF_W];
  end
  // Walk oldest to youngest so the last match (youngest) wins; registered state excludes this cycle's enqueue.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_data = '0;
    fwd_be = '0;
    idx = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (valid[idx] && entries[idx].addr == ld_w) begin
        fwd_hit = 1'b1;
        fwd_data = entries[idx].data[DATA_W-1:0];
        fwd_be = entries[idx].be[NB-1:0];
      end
    end
  end
  // When full, enqueue reuses the slot being drained, so the set of valid must follow the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      st_fault <= 1'b0;
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      st_fault <= st_valid && st_ready && al_fault;
      if (deq) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (enq) begin
        entries[wr_ptr] <= new_e;
        valid[wr_ptr] <= 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      count <= count + CNT_W'(enq) - CNT_W'(deq);
    end
  end
endmodule

// File: tb/tb_store_buffer_unit.sv
// tb_store_buffer_unit: directed vector table plus hand sequences for fill/stall, forwarding and reset.
module tb_store_buffer_unit;
  logic clk = 0, rst = 1;
  logic st_valid = 0, st_ready, st_fault, mem_valid, mem_ready = 0, fwd_hit;
  logic [1:0] st_size = 0;
  logic [31:0] st_addr = 0, st_data = 0, mem_addr, mem_wdata, ld_addr = 0, fwd_data;
  logic [3:0] mem_be, fwd_be;
  logic [2:0] count;
  int n_pass = 0, n_total = 0, xfers;

  store_buffer_unit dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready), .st_size(st_size),
    .st_addr(st_addr), .st_data(st_data), .st_fault(st_fault), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .ld_addr(ld_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_be(fwd_be), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] size;
    logic [31:0] addr, data;
    logic fault;
    logic [31:0] ea, ed;
    logic [3:0] eb;
  } vec_t;
  vec_t v [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    st_size = s;
    st_addr = a;
    st_data = d;
    st_valid = 1;
  endtask

  initial begin
    v[0] = '{2'b00, 32'h103, 32'h000000A5, 0, 32'h100, 32'hA5A5A5A5, 4'b1000};
    v[1] = '{2'b01, 32'h202, 32'h1234BEEF, 0, 32'h200, 32'hBEEFBEEF, 4'b1100};
    v[2] = '{2'b10, 32'h300, 32'hDEADBEEF, 0, 32'h300, 32'hDEADBEEF, 4'b1111};
    v[3] = '{2'b00, 32'h000, 32'h0000007F, 0, 32'h000, 32'h7F7F7F7F, 4'b0001};
    v[4] = '{2'b01, 32'h201, 32'h00001234, 1, 32'h0, 32'h0, 4'b0};
    v[5] = '{2'b10, 32'h102, 32'h11223344, 1, 32'h0, 32'h0, 4'b0};
    v[6] = '{2'b11, 32'h100, 32'h11223344, 1, 32'h0, 32'h0, 4'b0};
    v[7] = '{2'b01, 32'h400, 32'hFFFF8001, 0, 32'h400, 32'h80018001, 4'b0011};
    v[8] = '{2'b00, 32'h0FFFFFFE, 32'h000000C3, 0, 32'h0FFFFFFC, 32'hC3C3C3C3, 4'b0100};

    #2;
    chk("rst_count", count, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_fault", st_fault, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", mem_be, 0);
    step();
    rst = 0;
    #1;
    chk("ready_after_rst", st_ready, 1);

    for (int i = 0; i < 9; i++) begin
      put(v[i].size, v[i].addr, v[i].data);
      #1;
      chk($sformatf("v%0d_ready", i), st_ready, 1);
      chk($sformatf("v%0d_not_early", i), mem_valid, 0);
      step();
      st_valid = 0;
      chk($sformatf("v%0d_fault", i), st_fault, v[i].fault);
      chk($sformatf("v%0d_count", i), count, v[i].fault ? 0 : 1);
      chk($sformatf("v%0d_mem_valid", i), mem_valid, !v[i].fault);
      if (!v[i].fault) begin
        chk($sformatf("v%0d_addr", i), mem_addr, v[i].ea);
        chk($sformatf("v%0d_wdata", i), mem_wdata, v[i].ed);
        chk($sformatf("v%0d_be", i), mem_be, v[i].eb);
      end
      step();
      chk($sformatf("v%0d_fault_pulse", i), st_fault, 0);
      mem_ready = 1;
      step();
      mem_ready = 0;
      chk($sformatf("v%0d_drained", i), count, 0);
    end

    for (int i = 0; i < 4; i++) begin
      put(2'b10, 32'h10 * (i + 1), i + 1);
      step();
    end
    put(2'b10, 32'h50, 5);
    #1;
    chk("full_count", count, 4);
    chk("full_ready", st_ready, 0);
    chk("full_head_addr", mem_addr, 32'h10);
    step();
    chk("stall_count", count, 4);
    chk("stall_addr", mem_addr, 32'h10);
    chk("stall_wdata", mem_wdata, 1);
    chk("stall_be", mem_be, 4'hF);
    mem_ready = 1;
    #1;
    chk("full_drain_ready", st_ready, 1);
    step();
    st_valid = 0;
    chk("swap_count", count, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fifo%0d_addr", k), mem_addr, 32'h20 + 32'h10 * k);
      chk($sformatf("fifo%0d_data", k), mem_wdata, 2 + k);
      step();
    end
    mem_ready = 0;
    chk("fifo_empty", count, 0);

    ld_addr = 32'h200;
    put(2'b01, 32'h200, 32'h0000BEEF);
    #1;
    chk("fwd_inflight_miss", fwd_hit, 0);
    step();
    put(2'b00, 32'h201, 32'h00000011);
    #1;
    chk("fwd_old_be", fwd_be, 4'b0011);
    chk("fwd_old_data", fwd_data, 32'hBEEFBEEF);
    step();
    st_valid = 0;
    chk("fwd_hit", fwd_hit, 1);
    chk("fwd_young_be", fwd_be, 4'b0010);
    chk("fwd_young_data", fwd_data, 32'h11111111);
    ld_addr = 32'h204;
    #1;
    chk("fwd_miss_hit", fwd_hit, 0);
    chk("fwd_miss_data", fwd_data, 0);
    chk("fwd_miss_be", fwd_be, 0);
    ld_addr = 32'h203;
    mem_ready = 1;
    step();
    chk("fwd_draining_hit", fwd_hit, 1);
    chk("fwd_draining_be", fwd_be, 4'b0010);
    step();
    mem_ready = 0;
    chk("fwd_after_drain", fwd_hit, 0);

    for (int i = 0; i < 3; i++) begin
      put(2'b10, 32'h600 + 4 * i, 32'hA0 + i);
      step();
    end
    st_valid = 0;
    chk("pre_rst_count", count, 3);
    #2 rst = 1;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_valid", mem_valid, 0);
    chk("async_rst_fwd", fwd_hit, 0);
    #1 rst = 0;
    mem_ready = 1;
    xfers = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_valid && mem_ready) xfers++;
    end
    mem_ready = 0;
    chk("no_drain_after_rst", xfers, 0);
    chk("ready_post_rst", st_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
